// File: rtl/axi_chan_fifo_sync.sv
// ---------------------------------------------------------------------------
// axi_chan_fifo_sync
//
// Single-clock FIFO that buffers one AXI channel (AR/AW/W/R/B) between the
// bridge and a slave wrapper in the same clock domain. The read side is
// first-word-fall-through: the head entry is always driven on rdata, and
// rdata is all-zero while the FIFO is empty.
//
// Handshake semantics: a write is accepted on a rising edge when
// wpush=1 and wfull=0; a read is accepted when rpop=1 and rempty=0.
// wfull/rempty act as "not ready"/"not valid" and come only from registered
// pointers, so they never depend on wpush/rpop in the same cycle. A request
// made against a full/empty FIFO is dropped and latches a sticky error flag.
//
// Parameters
//   DATA_W   payload width (default 49 = AR packing: id/addr/len/size/burst)
//   DEPTH    number of entries, power of two, >= 2
//   AFULL_TH walmost_full threshold, 1..DEPTH
//
// Ports
//   clk, rst      clock, synchronous active-high reset
//   flush         synchronous clear of contents (error flags are kept)
//   wpush, wdata  write request and payload
//   wfull         no free entry
//   walmost_full  count >= AFULL_TH
//   rpop          read request, consumes the head entry
//   rdata         head entry, zero when empty
//   rempty        no valid entry
//   count         occupancy 0..DEPTH
//   ovf_err       sticky: push attempted while full
//   udf_err       sticky: pop attempted while empty
// ---------------------------------------------------------------------------
module axi_chan_fifo_sync #(
  parameter int DATA_W   = 49,
  parameter int DEPTH    = 4,
  parameter int AFULL_TH = DEPTH - 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       wpush,
  input  logic [DATA_W-1:0]          wdata,
  output logic                       wfull,
  output logic                       walmost_full,
  input  logic                       rpop,
  output logic [DATA_W-1:0]          rdata,
  output logic                       rempty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       ovf_err,
  output logic                       udf_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] AFULL_C = (AW+1)'(AFULL_TH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  // when the index bits match.
  logic [AW:0]       wptr_q, wptr_d;
  logic [AW:0]       rptr_q, rptr_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  logic              empty_w;
  logic              full_w;
  logic [AW:0]       count_w;
  logic              wen;
  logic              ren;

  // Status purely from registered pointers.
  always_comb begin
    empty_w = (wptr_q == rptr_q);
    full_w  = (wptr_q[AW] != rptr_q[AW]) &&
              (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    count_w = wptr_q - rptr_q;
  end

  // Flush wins over both requests, so nothing is written or consumed then.
  always_comb begin
    wen = wpush & ~full_w & ~flush;
    ren = rpop & ~empty_w & ~flush;
  end

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (wen) wptr_d = wptr_q + PTR_ONE;
      if (ren) rptr_d = rptr_q + PTR_ONE;
    end
  end

  // Error flags are sticky until reset; a flush cycle never sets them.
  always_comb begin
    ovf_d = ovf_q | (wpush & full_w & ~flush);
    udf_d = udf_q | (rpop & empty_w & ~flush);
  end

  always_comb begin
    mem_d = mem_q;
    if (wen) mem_d[wptr_q[AW-1:0]] = wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      ovf_q  <= ovf_d;
      udf_q  <= udf_d;
    end
  end

  // Storage is deliberately not reset; stale words are hidden by the
  // zero-gating of rdata while empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_comb begin
    wfull        = full_w;
    rempty       = empty_w;
    count        = count_w;
    walmost_full = (count_w >= AFULL_C);
    rdata        = empty_w ? '0 : mem_q[rptr_q[AW-1:0]];
    ovf_err      = ovf_q;
    udf_err      = udf_q;
  end

endmodule

// File: tb/tb_axi_chan_fifo_sync.sv
// ---------------------------------------------------------------------------
// tb_axi_chan_fifo_sync
//
// Directed bench for axi_chan_fifo_sync (DEPTH=4, DATA_W=49). Inputs change
// on the falling edge, the DUT samples on the rising edge, and outputs are
// checked on the following falling edge. exp_q holds the words the FIFO
// should contain, oldest first; its size is the expected occupancy.
// ---------------------------------------------------------------------------
module tb_axi_chan_fifo_sync;

  localparam int DATA_W   = 49;
  localparam int DEPTH    = 4;
  localparam int AW       = 2;
  localparam int AFULL_TH = DEPTH - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              wpush;
  logic [DATA_W-1:0] wdata;
  logic              wfull;
  logic              walmost_full;
  logic              rpop;
  logic [DATA_W-1:0] rdata;
  logic              rempty;
  logic [AW:0]       count;
  logic              ovf_err;
  logic              udf_err;

  logic [DATA_W-1:0] exp_q[$];
  logic              m_ovf;
  logic              m_udf;
  int                n_pass  = 0;
  int                n_fail  = 0;
  int                n_total = 0;

  axi_chan_fifo_sync #(
    .DATA_W  (DATA_W),
    .DEPTH   (DEPTH),
    .AFULL_TH(AFULL_TH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .wpush       (wpush),
    .wdata       (wdata),
    .wfull       (wfull),
    .walmost_full(walmost_full),
    .rpop        (rpop),
    .rdata       (rdata),
    .rempty      (rempty),
    .count       (count),
    .ovf_err     (ovf_err),
    .udf_err     (udf_err)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    int sz;
    logic [DATA_W-1:0] head;
    sz   = exp_q.size();
    head = (sz > 0) ? exp_q[0] : '0;
    chk({tag, ".count"},  64'(count),        64'(sz));
    chk({tag, ".rempty"}, 64'(rempty),       64'(sz == 0));
    chk({tag, ".wfull"},  64'(wfull),        64'(sz == DEPTH));
    chk({tag, ".afull"},  64'(walmost_full), 64'(sz >= AFULL_TH));
    chk({tag, ".ovf"},    64'(ovf_err),      64'(m_ovf));
    chk({tag, ".udf"},    64'(udf_err),      64'(m_udf));
    chk({tag, ".rdata"},  64'(rdata),        64'(head));
  endtask

  // ---------------- drivers ----------------
  // Called on a falling edge; applies one cycle of requests, updates the
  // expected contents, then checks the outputs on the next falling edge.
  task automatic cycle(input string tag, input logic push,
                       input logic [DATA_W-1:0] d, input logic pop,
                       input logic fl);
    logic was_full;
    logic was_empty;
    wpush = push;
    wdata = d;
    rpop  = pop;
    flush = fl;
    was_full  = (exp_q.size() == DEPTH);
    was_empty = (exp_q.size() == 0);
    // The word being consumed must be the oldest one still held.
    if (!fl && pop && !was_empty) chk({tag, ".pop_data"}, 64'(rdata), 64'(exp_q[0]));
    if (fl) begin
      exp_q.delete();
    end else begin
      if (push && was_full)  m_ovf = 1'b1;
      if (pop && was_empty)  m_udf = 1'b1;
      if (pop && !was_empty) void'(exp_q.pop_front());
      if (push && !was_full) exp_q.push_back(d);
    end
    @(negedge clk);
    wpush = 1'b0;
    rpop  = 1'b0;
    flush = 1'b0;
    check_state(tag);
  endtask

  task automatic do_reset(input string tag);
    rst   = 1'b1;
    wpush = 1'b0;
    rpop  = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    check_state(tag);
  endtask

  function automatic logic [DATA_W-1:0] rnd_word();
    return DATA_W'({$urandom(), $urandom()});
  endfunction

  // ---------------- directed sequence ----------------
  initial begin
    logic [DATA_W-1:0] base;
    base  = 49'h1_0000_0000_0000;
    rst   = 1'b1;
    flush = 1'b0;
    wpush = 1'b0;
    rpop  = 1'b0;
    wdata = '0;
    m_ovf = 1'b0;
    m_udf = 1'b0;

    // Reset state
    do_reset("reset");

    // Fill: count 1..4, almost-full at 3, full at 4, then overflow attempt
    for (int i = 1; i <= 4; i++) cycle("fill", 1'b1, base + DATA_W'(i), 1'b0, 1'b0);
    cycle("push_full", 1'b1, base + DATA_W'(5), 1'b0, 1'b0);

    // Drain in order, then underflow attempt
    for (int i = 0; i < 4; i++) cycle("drain", 1'b0, '0, 1'b1, 1'b0);
    cycle("pop_empty", 1'b0, '0, 1'b1, 1'b0);

    // Wrap-around streaming at steady occupancy 2, error flags clear
    do_reset("reset2");
    cycle("prefill", 1'b1, rnd_word(), 1'b0, 1'b0);
    cycle("prefill", 1'b1, rnd_word(), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cycle("stream", 1'b1, rnd_word(), 1'b1, 1'b0);

    // Simultaneous push+pop while full
    cycle("fill2", 1'b1, rnd_word(), 1'b0, 1'b0);
    cycle("fill2", 1'b1, rnd_word(), 1'b0, 1'b0);
    cycle("pp_full", 1'b1, rnd_word(), 1'b1, 1'b0);

    // Simultaneous push+pop while empty
    for (int i = 0; i < 3; i++) cycle("drain2", 1'b0, '0, 1'b1, 1'b0);
    cycle("pp_empty", 1'b1, rnd_word(), 1'b1, 1'b0);

    // Flush with 3 entries and a concurrent push
    cycle("fill3", 1'b1, rnd_word(), 1'b0, 1'b0);
    cycle("fill3", 1'b1, rnd_word(), 1'b0, 1'b0);
    cycle("flush", 1'b1, rnd_word(), 1'b0, 1'b1);

    // Reset while holding 2 entries with ovf_err set, then normal use
    do_reset("reset3");
    for (int i = 0; i < 5; i++) cycle("fill4", 1'b1, rnd_word(), 1'b0, 1'b0);
    cycle("drain4", 1'b0, '0, 1'b1, 1'b0);
    cycle("drain4", 1'b0, '0, 1'b1, 1'b0);
    do_reset("reset_mid");
    cycle("post_push", 1'b1, rnd_word(), 1'b0, 1'b0);
    cycle("post_push", 1'b1, rnd_word(), 1'b0, 1'b0);
    cycle("post_pop", 1'b0, '0, 1'b1, 1'b0);
    cycle("post_pop", 1'b0, '0, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
